// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the fifo_reader consumer controller: FSM state
// encoding and the skid-buffer pointer-width helper.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    ERROR  = 2'd3
  } state_e;

  // log2 of a power-of-two depth, never narrower than one bit
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Circular skid buffer for fifo_reader: push at the tail, pop from the head,
// head word and occupancy exposed combinationally.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    push_i,
  input  logic [W-1:0]            push_data_i,
  input  logic                    pop_i,
  output logic [W-1:0]            head_o,
  output logic [ptr_w(DEPTH):0]   count_o,
  output logic                    valid_o
);

  localparam int unsigned PW = ptr_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign valid_o = (cnt_q != '0);

  // Depth is a power of two, so natural pointer overflow is the modulo wrap
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Consumer-side FIFO read controller: pops the FIFO, absorbs its read latency
// into a skid buffer and streams valid/ready downstream.
// Optional FIFO_READER_STATS_EN adds words_cnt / stall_cnt outputs.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned BITNUMBER  = 8,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Fifo_empty,
  input  logic                 Fifo_almost_empty,
  input  logic                 Fifo_rd_error,
  input  logic [BITNUMBER-1:0] Fifo_Data_out,
  output logic                 Fifo_rd,
  input  logic                 ready_in,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 valid_out,
  input  logic                 err_clr,
  output logic                 rd_error_sticky,
  output logic                 busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [15:0]          words_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int unsigned PW = ptr_w(SKID_DEPTH);
  localparam int unsigned CW = PW + 2;

  state_e            state_q, state_d;
  logic              rd_q, rd_d;
  logic [RD_LAT-1:0] sr_q, sr_d;
  logic [CW-1:0]     inflight_cnt;
  logic [PW:0]       skid_cnt;
  logic              credit;
  logic              capture;
  logic              pop;

  // sr_q[0] mirrors the Fifo_rd now on the wire; its data is captured when the
  // bit leaves the top, RD_LAT edges after the assertion edge
  always_comb begin
    sr_d    = '0;
    sr_d[0] = rd_d;
    for (int unsigned i = 1; i < RD_LAT; i++) sr_d[i] = sr_q[i-1];
  end

  always_comb begin
    inflight_cnt = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight_cnt = inflight_cnt + CW'(sr_q[i]);
  end

  assign capture = sr_q[RD_LAT-1];
  assign pop     = valid_out && ready_in;
  assign credit  = (inflight_cnt + CW'(skid_cnt)) < CW'(SKID_DEPTH);
  assign busy    = (inflight_cnt != '0) || (skid_cnt != '0);
  assign Fifo_rd = rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (Fifo_rd_error) begin
      state_d = ERROR;
    end else begin
      case (state_q)
        IDLE:    if (rd_d) state_d = STREAM;
        STREAM:  if (Fifo_empty) state_d = busy ? DRAIN : IDLE;
        DRAIN: begin
          if (!Fifo_empty) state_d = STREAM;
          else if (!busy)  state_d = IDLE;
        end
        ERROR:   if (err_clr) state_d = busy ? DRAIN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Almost-empty with a pop already on the wire means the flag is stale
  always_comb begin
    rd_d = ((state_q == IDLE) || (state_q == STREAM)) &&
           !Fifo_empty && credit &&
           !(Fifo_almost_empty && rd_q) &&
           !Fifo_rd_error;
    rd_error_sticky = (state_q == ERROR);
  end

  fifo_reader_skid #(
    .W     (BITNUMBER),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (capture),
    .push_data_i (Fifo_Data_out),
    .pop_i       (pop),
    .head_o      (data_out),
    .count_o     (skid_cnt),
    .valid_o     (valid_out)
  );

`ifdef FIFO_READER_STATS_EN
  logic [15:0] words_q;
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (valid_out && ready_in)  words_q <= words_q + 16'd1;
      if (valid_out && !ready_in) stall_q <= stall_q + 16'd1;
    end
  end

  assign words_cnt = words_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural registered-read FIFO.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Fifo_empty = 1'b1;
  logic       Fifo_almost_empty = 1'b0;
  logic       Fifo_rd_error = 1'b0;
  logic [7:0] Fifo_Data_out = 8'h00;
  logic       Fifo_rd;
  logic       ready_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       err_clr = 1'b0;
  logic       rd_error_sticky;
  logic       busy;
`ifdef FIFO_READER_STATS_EN
  logic [15:0] words_cnt;
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] fq[$];
  logic [7:0] rx[$];
  int rd_count;
  int err_seen;
  int cyc = 0;
  int first_rd;
  int first_v;
  int rd_run, rd_run_max, xf_run, xf_run_max;

  always #5 clk = ~clk;

  fifo_reader #(
    .BITNUMBER  (8),
    .RD_LAT     (2),
    .SKID_DEPTH (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .Fifo_empty        (Fifo_empty),
    .Fifo_almost_empty (Fifo_almost_empty),
    .Fifo_rd_error     (Fifo_rd_error),
    .Fifo_Data_out     (Fifo_Data_out),
    .Fifo_rd           (Fifo_rd),
    .ready_in          (ready_in),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .err_clr           (err_clr),
    .rd_error_sticky   (rd_error_sticky),
    .busy              (busy)
`ifdef FIFO_READER_STATS_EN
    ,
    .words_cnt         (words_cnt),
    .stall_cnt         (stall_cnt)
`endif
  );

  // One clock: sample DUT mid-cycle, then advance the FIFO model after the edge
  task automatic tick();
    logic       rd_s, xf;
    logic [7:0] d;
    rd_s = Fifo_rd;
    xf   = valid_out && ready_in;
    d    = data_out;
    if (rd_s) begin
      rd_count++;
      rd_run++;
      if (first_rd < 0) first_rd = cyc;
      if (rd_run > rd_run_max) rd_run_max = rd_run;
    end else rd_run = 0;
    if (valid_out && first_v < 0) first_v = cyc;
    if (xf) begin
      rx.push_back(d);
      xf_run++;
      if (xf_run > xf_run_max) xf_run_max = xf_run;
    end else xf_run = 0;
    @(posedge clk);
    #1;
    Fifo_rd_error = 1'b0;
    if (rd_s) begin
      if (fq.size() == 0) begin
        Fifo_rd_error = 1'b1;
        err_seen++;
      end else Fifo_Data_out = fq.pop_front();
    end
    Fifo_empty        = (fq.size() == 0);
    Fifo_almost_empty = (fq.size() == 1);
    cyc++;
  endtask

  task automatic clear_stats();
    rx.delete();
    rd_count = 0; err_seen = 0;
    first_rd = -1; first_v = -1;
    rd_run = 0; rd_run_max = 0; xf_run = 0; xf_run_max = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ready_in = 1'b0;
    err_clr = 1'b0;
    fq.delete();
    Fifo_empty = 1'b1;
    Fifo_almost_empty = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    clear_stats();
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(first + 8'(i));
    Fifo_empty        = (fq.size() == 0);
    Fifo_almost_empty = (fq.size() == 1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (Fifo_rd !== 1'b0 || valid_out !== 1'b0 || data_out !== 8'h00 ||
        rd_error_sticky !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b valid=%b data=%h sticky=%b busy=%b, required all 0",
               Fifo_rd, valid_out, data_out, rd_error_sticky, busy);
    end
`ifdef FIFO_READER_STATS_EN
    checks++;
    if (words_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stats: words=%0d stall=%0d, required 0 0", words_cnt, stall_cnt);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_stream();
    int start;
    do_reset();
    ready_in = 1'b1;
    load(8'h11, 8);
    start = cyc;
    for (int n = 0; n < 60 && rx.size() < 8; n++) tick();
    checks++;
    if (rd_count != 8 || rd_run_max != 8) begin
      errors++;
      $display("FAIL stream_reads: count=%0d run=%0d, required 8 8", rd_count, rd_run_max);
    end
    checks++;
    if (first_rd - start != 1 || first_v - start != 3) begin
      errors++;
      $display("FAIL stream_latency: rd at +%0d valid at +%0d, required +1 +3",
               first_rd - start, first_v - start);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx.size() <= i) begin
        errors++;
        $display("FAIL stream_word%0d: missing, required %h", i, 8'h11 + 8'(i));
      end else if (rx[i] !== 8'h11 + 8'(i)) begin
        errors++;
        $display("FAIL stream_word%0d: got %h, required %h", i, rx[i], 8'h11 + 8'(i));
      end
    end
    checks++;
    if (xf_run_max != 8) begin
      errors++;
      $display("FAIL stream_consecutive: run=%0d, required 8", xf_run_max);
    end
    for (int n = 0; n < 3; n++) tick();
    checks++;
    if (busy !== 1'b0 || 2'(dut.state_q) !== 2'd0 || err_seen != 0) begin
      errors++;
      $display("FAIL stream_idle: busy=%b state=%0d errs=%0d, required 0 0 0",
               busy, 2'(dut.state_q), err_seen);
    end
  endtask

  task automatic test_underflow_guard();
    do_reset();
    ready_in = 1'b1;
    load(8'hA5, 1);
    for (int n = 0; n < 12; n++) tick();
    checks++;
    if (rd_count != 1 || err_seen != 0) begin
      errors++;
      $display("FAIL underflow_reads: count=%0d rd_errors=%0d, required 1 0", rd_count, err_seen);
    end
    checks++;
    if (rx.size() != 1 || rx[0] !== 8'hA5) begin
      errors++;
      $display("FAIL underflow_data: words=%0d first=%h, required 1 a5",
               rx.size(), (rx.size() > 0) ? rx[0] : 8'hxx);
    end
  endtask

  task automatic test_backpressure();
    int unstable;
    do_reset();
    unstable = 0;
    load(8'h21, 8);
    for (int n = 0; n < 10; n++) begin
      if (valid_out && data_out !== 8'h21) unstable++;
      tick();
    end
    checks++;
    if (rd_count != 4) begin
      errors++;
      $display("FAIL bp_reads: count=%0d, required 4", rd_count);
    end
    checks++;
    if (unstable != 0 || valid_out !== 1'b1 || data_out !== 8'h21) begin
      errors++;
      $display("FAIL bp_hold: unstable=%0d valid=%b data=%h, required 0 1 21",
               unstable, valid_out, data_out);
    end
    ready_in = 1'b1;
    for (int n = 0; n < 60 && rx.size() < 8; n++) tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx.size() <= i || rx[i] !== 8'h21 + 8'(i)) begin
        errors++;
        $display("FAIL bp_word%0d: got %h, required %h", i,
                 (rx.size() > i) ? rx[i] : 8'hxx, 8'h21 + 8'(i));
      end
    end
  endtask

  task automatic test_error();
    do_reset();
    load(8'h31, 6);
    for (int n = 0; n < 8; n++) tick();
    Fifo_rd_error = 1'b1;
    tick();
    rd_count = 0;
    checks++;
    if (rd_error_sticky !== 1'b1 || Fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL err_set: sticky=%b rd=%b, required 1 0", rd_error_sticky, Fifo_rd);
    end
    ready_in = 1'b1;
    tick();
    tick();
    Fifo_rd_error = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (rd_error_sticky !== 1'b1 || 2'(dut.state_q) !== 2'd3) begin
      errors++;
      $display("FAIL err_wins: sticky=%b state=%0d, required 1 3", rd_error_sticky, 2'(dut.state_q));
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (rd_count != 0 || rx.size() != 4) begin
      errors++;
      $display("FAIL err_drain: reads=%0d delivered=%0d, required 0 4", rd_count, rx.size());
    end
    checks++;
    if (rd_error_sticky !== 1'b0 || 2'(dut.state_q) !== 2'd2) begin
      errors++;
      $display("FAIL err_clear: sticky=%b state=%0d, required 0 2", rd_error_sticky, 2'(dut.state_q));
    end
    for (int n = 0; n < 40 && rx.size() < 6; n++) tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rx.size() <= i || rx[i] !== 8'h31 + 8'(i)) begin
        errors++;
        $display("FAIL err_word%0d: got %h, required %h", i,
                 (rx.size() > i) ? rx[i] : 8'hxx, 8'h31 + 8'(i));
      end
    end
    for (int n = 0; n < 3; n++) tick();
    checks++;
    if (busy !== 1'b0 || 2'(dut.state_q) !== 2'd0 || rd_count != 2) begin
      errors++;
      $display("FAIL err_final: busy=%b state=%0d reads=%0d, required 0 0 2",
               busy, 2'(dut.state_q), rd_count);
    end
  endtask

  task automatic test_reset_midstream();
    int late_valid;
    do_reset();
    late_valid = 0;
    load(8'h41, 8);
    for (int n = 0; n < 4; n++) tick();
    checks++;
    if (busy !== 1'b1 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: busy=%b valid=%b, required 1 1", busy, valid_out);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fq.delete();
    Fifo_empty = 1'b1;
    Fifo_almost_empty = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || Fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b rd=%b, required 0 0 0", valid_out, busy, Fifo_rd);
    end
    ready_in = 1'b1;
    for (int n = 0; n < 6; n++) begin
      if (valid_out || busy) late_valid++;
      tick();
    end
    checks++;
    if (late_valid != 0) begin
      errors++;
      $display("FAIL mid_late_data: active cycles=%0d, required 0", late_valid);
    end
  endtask

`ifdef FIFO_READER_STATS_EN
  task automatic test_stats();
    do_reset();
    load(8'h51, 5);
    for (int n = 0; n < 20 && !valid_out; n++) tick();
    for (int n = 0; n < 3; n++) tick();
    ready_in = 1'b1;
    for (int n = 0; n < 30 && rx.size() < 5; n++) tick();
    checks++;
    if (words_cnt !== 16'd5 || stall_cnt !== 16'd3) begin
      errors++;
      $display("FAIL stats: words=%0d stall=%0d, required 5 3", words_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    clear_stats();
    test_reset();
    test_stream();
    test_underflow_guard();
    test_backpressure();
    test_error();
    test_reset_midstream();
`ifdef FIFO_READER_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
